branch_resolve_unit: RTL
========================

BRANCH_RESOLVE_UNIT -- requirements
Module: branch_resolve_unit

Interface
REQ-001 SHALL have parameter XLEN, default 32: data/address width in bits, at least 32.
REQ-002 SHALL have parameter BHT_DEPTH, default 16: number of 2-bit counters, a power of two, at least 2.
REQ-003 SHALL have port clk, input, 1 bit: the single clock, rising edge.
REQ-004 SHALL have port rst_n, input, 1 bit: reset, synchronous and active-low.
REQ-005 SHALL have port clk_en, input, 1 bit: stage enable; while low, every register and BHT entry holds its value.
REQ-006 SHALL have port in_valid, input, 1 bit: a control-transfer instruction is presented this cycle.
REQ-007 SHALL have port flush, input, 1 bit: kills the presented instruction.
REQ-008 SHALL have ports rs1, rs2, imm and pc, input, XLEN each: operands, sign-extended immediate, and instruction PC.
REQ-009 SHALL have port funct3, input, 3 bits: branch condition (BEQ 000, BNE 001, BLT 100, BGE 101, BLTU 110, BGEU 111).
REQ-010 SHALL have ports cbranch and ubranch, input, 1 bit each: conditional and unconditional branch decoded.
REQ-011 SHALL have port base_sel, input, 1 bit: target base, 0 = pc, 1 = rs1.
REQ-012 SHALL have port pred_taken, input, 1 bit: the prediction fetch used for this instruction.
REQ-013 SHALL have port lookup_pc, input, XLEN: fetch-side PC for the prediction lookup.
REQ-014 SHALL have port lookup_taken, output, 1 bit: combinational MSB of BHT[lookup_pc index].
REQ-015 SHALL have ports res_valid, res_taken, res_mispredict and res_misaligned, output, 1 bit each: registered results.
REQ-016 SHALL have ports res_target and res_redirect_pc, output, XLEN each: registered target and correct next PC.

Function
REQ-017 SHALL derive the BHT index as pc[log2(BHT_DEPTH)+1:2], for both lookup and update.
REQ-018 SHALL compute target = base + imm over full XLEN, wrapping modulo 2^XLEN, and clear bit 0 when base_sel=1.
REQ-019 SHALL evaluate the condition for funct3 values 010 and 011 as not taken.
REQ-020 SHALL set taken = (cbranch and condition true) or ubranch, with cbranch taking priority when both are high.
REQ-021 SHALL have a latency of one cycle: when clk_en=1, in_valid=1 and flush=0, res_* at the next edge reflect that instruction.
REQ-022 SHALL register res_valid=0 at a clk_en=1 edge where in_valid=0 or flush=1, holding the other res_* outputs unchanged.
REQ-023 SHALL set res_redirect_pc = target when taken, otherwise pc+4 (wrapping).
REQ-024 SHALL set res_mispredict = taken XOR pred_taken.
REQ-025 SHALL update the counter at pc's index on each accepted cbranch (not ubranch, not flushed): +1 when taken saturating at 3, -1 when not taken saturating at 0.
REQ-026 SHALL return the pre-update counter value on lookup_taken when lookup and update hit the same index in the same cycle (no bypass).

Reset
REQ-027 SHALL, while rst_n=0 at a clock edge regardless of clk_en, clear res_valid, res_taken, res_mispredict and res_misaligned to 0 and res_target and res_redirect_pc to 0.
REQ-028 SHALL set every BHT counter to 01 (weakly not-taken) on reset.
REQ-029 SHALL discard an instruction presented during the reset cycle, with no result and no BHT update.

Configuration
REQ-030 SHALL, when BRU_MISALIGN_CHECK_EN is defined, flag a taken instruction whose target[1:0] != 00 with res_misaligned=1 and res_mispredict=0, and skip the BHT update; res_valid=1 and res_redirect_pc=target still apply.
REQ-031 SHALL, when BRU_MISALIGN_CHECK_EN is undefined, tie res_misaligned to 0 and give misaligned targets no special handling.

Verification
REQ-032 SHALL verify: reset, then lookup_pc=0x40 -> lookup_taken=0 and all res_* outputs = 0.
REQ-033 SHALL verify: cbranch BLT, rs1=0xFFFFFFFF, rs2=1, pc=0x100, imm=0x20, pred_taken=0 -> next cycle res_taken=1, res_mispredict=1, res_redirect_pc=0x120, BHT[0] = 10.
REQ-034 SHALL verify: BLTU with the same operands, pc=0x100 -> res_taken=0, res_redirect_pc=0x104; three more not-taken updates leave BHT[0] saturated at 00.
REQ-035 SHALL verify: ubranch with base_sel=1, rs1=0x1001, imm=0x4 -> res_target=0x1004 and no BHT change; with the macro defined, imm=0x6 gives target 0x1006 and res_misaligned=1.
REQ-036 SHALL verify: clk_en=0 for 3 cycles with in_valid=1 -> outputs and BHT frozen; flush=1 -> res_valid=0 and no BHT update.
REQ-037 SHALL verify: pc=0xFFFFFFFC, not taken -> res_redirect_pc=0x0; a lookup and update hitting the same index in one cycle -> lookup_taken shows the old counter value.

Source files
------------

// File: rtl/branch_resolve_unit.sv
// ============================================================================
//  Module      : branch_resolve_unit
//  Description : Resolves conditional/unconditional control transfers one
//                cycle after issue and trains a 2-bit-counter branch history
//                table. Optional macro BRU_MISALIGN_CHECK_EN enables
//                misaligned-target flagging.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module branch_resolve_unit #(
   parameter int XLEN      = 32,
   parameter int BHT_DEPTH = 16
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            clk_en,
   input  logic            in_valid,
   input  logic            flush,
   input  logic [XLEN-1:0] rs1,
   input  logic [XLEN-1:0] rs2,
   input  logic [XLEN-1:0] imm,
   input  logic [XLEN-1:0] pc,
   input  logic [2:0]      funct3,
   input  logic            cbranch,
   input  logic            ubranch,
   input  logic            base_sel,
   input  logic            pred_taken,
   input  logic [XLEN-1:0] lookup_pc,
   output logic            lookup_taken,
   output logic            res_valid,
   output logic            res_taken,
   output logic            res_mispredict,
   output logic            res_misaligned,
   output logic [XLEN-1:0] res_target,
   output logic [XLEN-1:0] res_redirect_pc
);

   localparam int              IDX_W     = $clog2(BHT_DEPTH);
   localparam logic [XLEN-1:0] c_pc_step = XLEN'(4);

   logic [1:0]      r_bht [BHT_DEPTH];
   logic            r_res_valid;
   logic            r_res_taken;
   logic            r_res_mispredict;
   logic            r_res_misaligned;
   logic [XLEN-1:0] r_res_target;
   logic [XLEN-1:0] r_res_redirect_pc;

   logic [IDX_W-1:0] w_lookup_idx;
   logic [IDX_W-1:0] w_upd_idx;
   logic             w_eq;
   logic             w_lt;
   logic             w_ltu;
   logic             w_cond;
   logic [XLEN-1:0]  w_base;
   logic [XLEN-1:0]  w_sum;
   logic [XLEN-1:0]  w_target;
   logic [XLEN-1:0]  w_seq_pc;
   logic             w_taken;
   logic             w_misaligned;
   logic             w_mispredict;
   logic             w_accept;
   logic             w_bht_upd;
   logic [1:0]       w_bht_cur;
   logic [1:0]       w_bht_next;
   logic             w_unused_lookup;

   // Word-aligned PCs: the two LSBs never select a counter.
   assign w_lookup_idx    = lookup_pc[IDX_W+1:2];
   assign w_upd_idx       = pc[IDX_W+1:2];
   assign w_unused_lookup = ^{lookup_pc[XLEN-1:IDX_W+2], lookup_pc[1:0]};

   assign w_eq  = (rs1 == rs2);
   assign w_lt  = ($signed(rs1) < $signed(rs2));
   assign w_ltu = (rs1 < rs2);

   always_comb begin
      w_cond = 1'b0;
      case (funct3)
         3'b000:  w_cond = w_eq;
         3'b001:  w_cond = ~w_eq;
         3'b100:  w_cond = w_lt;
         3'b101:  w_cond = ~w_lt;
         3'b110:  w_cond = w_ltu;
         3'b111:  w_cond = ~w_ltu;
         default: w_cond = 1'b0;
      endcase
   end

   assign w_base   = base_sel ? rs1 : pc;
   assign w_sum    = w_base + imm;
   assign w_target = base_sel ? {w_sum[XLEN-1:1], 1'b0} : w_sum;
   assign w_seq_pc = pc + c_pc_step;
   assign w_taken  = cbranch ? w_cond : ubranch;

`ifdef BRU_MISALIGN_CHECK_EN
   assign w_misaligned = w_taken & (w_target[1:0] != 2'b00);
`else
   assign w_misaligned = 1'b0;
`endif

   // A misaligned target traps, so it is neither a mispredict nor training data.
   assign w_mispredict = (w_taken ^ pred_taken) & ~w_misaligned;
   assign w_accept     = in_valid & ~flush;
   assign w_bht_upd    = w_accept & cbranch & ~w_misaligned;

   assign w_bht_cur = r_bht[w_upd_idx];

   always_comb begin
      w_bht_next = w_bht_cur;
      if (w_taken) begin
         if (w_bht_cur != 2'b11) w_bht_next = w_bht_cur + 2'b01;
      end else begin
         if (w_bht_cur != 2'b00) w_bht_next = w_bht_cur - 2'b01;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         for (int i = 0; i < BHT_DEPTH; i++) r_bht[i] <= 2'b01;
      end else if (clk_en && w_bht_upd) begin
         r_bht[w_upd_idx] <= w_bht_next;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_res_valid       <= 1'b0;
         r_res_taken       <= 1'b0;
         r_res_mispredict  <= 1'b0;
         r_res_misaligned  <= 1'b0;
         r_res_target      <= '0;
         r_res_redirect_pc <= '0;
      end else if (clk_en) begin
         r_res_valid <= w_accept;
         if (w_accept) begin
            r_res_taken       <= w_taken;
            r_res_mispredict  <= w_mispredict;
            r_res_misaligned  <= w_misaligned;
            r_res_target      <= w_target;
            r_res_redirect_pc <= w_taken ? w_target : w_seq_pc;
         end
      end
   end

   // No bypass: a same-cycle update becomes visible only after the edge.
   assign lookup_taken    = r_bht[w_lookup_idx][1];
   assign res_valid       = r_res_valid;
   assign res_taken       = r_res_taken;
   assign res_mispredict  = r_res_mispredict;
   assign res_misaligned  = r_res_misaligned;
   assign res_target      = r_res_target;
   assign res_redirect_pc = r_res_redirect_pc;

endmodule

`default_nettype wire
